// File: rtl/bitcoin_nonce_search.sv
// bitcoin_nonce_search: double-SHA-256 nonce sweep over a 20-word block header.
//
// Flow: READ the header (21 cycles). P1 computes the first-block midstate
// once (66 cycles). Then, for each pass, P2 and P3 run NUM_LANES
// double-SHA-256 lanes in parallel (66 cycles each), and WRITE stores one h0
// per lane (NUM_LANES cycles). Each lane's h0 is compared against the target.
// The lowest-index winner of the run is kept in found/found_nonce.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           one-cycle pulse, accepted only while done=1
//   message_addr    base address of the 20 header words
//   output_addr     base address of the h0 output words
//   nonce_base      nonce of lane 0 in pass 0
//   target          a lane wins when its h0 < target (unsigned)
//   done            high while idle
//   found           a winner was seen in the last run
//   found_nonce     nonce of the lowest-index winner
//   mem_*           memory port; read data arrives one cycle after its address
//
// Each phase (P1/P2/P3) uses cnt as follows:
//   cnt 0        load
//   cnt 1..64    rounds
//   cnt 65       fold

// One SHA-256 compression engine: one round per cycle, 16-word schedule window.
//   load      a..h <= chain_in, window <= blk, chain kept for the fold
//   step      one round using round constant k and window word 0
//   fold      digest <= chain + a..h
//   fold_h0   combinational chain[0] + a, valid in the fold cycle
module bitcoin_nonce_search_lane (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             fold,
  input  logic [31:0]      k,
  input  logic [15:0][31:0] blk,
  input  logic [7:0][31:0] chain_in,
  output logic [31:0]      fold_h0,
  output logic [7:0][31:0] digest
);
  logic [7:0][31:0]  chain, st, st_n, fold_sum;
  logic [15:0][31:0] w;
  logic [31:0]       s0, s1, ch, mj, t1, t2, w_new;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    ror = (x >> n) | (x << (32 - n));
  endfunction

  // st[0]=a ... st[7]=h
  always_comb begin
    s1    = ror(st[4], 6) ^ ror(st[4], 11) ^ ror(st[4], 25);
    ch    = (st[4] & st[5]) ^ (~st[4] & st[6]);
    t1    = st[7] + s1 + ch + k + w[0];
    s0    = ror(st[0], 2) ^ ror(st[0], 13) ^ ror(st[0], 22);
    mj    = (st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]);
    t2    = s0 + mj;
    st_n  = {st[6:4], st[3] + t1, st[2:0], t1 + t2};
    // W[t+16] from the window holding W[t..t+15]
    w_new = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10)) + w[9] +
            (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[0];
    for (int i = 0; i < 8; i++) fold_sum[i] = chain[i] + st[i];
  end

  assign fold_h0 = fold_sum[0];

  always_ff @(posedge clk) begin
    if (load) begin
      chain <= chain_in;
      st    <= chain_in;
      w     <= blk;
    end else if (step) begin
      st <= st_n;
      w  <= {w_new, w[15:1]};
    end
    if (fold) digest <= fold_sum;
  end
endmodule

module bitcoin_nonce_search #(
  parameter int NUM_LANES    = 8,
  parameter int NUM_PASSES   = 2,
  parameter int STOP_ON_FIND = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] nonce_base,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] P1    = 3'd2;
  localparam logic [2:0] P2    = 3'd3;
  localparam logic [2:0] P3    = 3'd4;
  localparam logic [2:0] WRITE = 3'd5;

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [2:0]        state;
  logic [6:0]        cnt;
  logic [PW-1:0]     pass;
  logic [31:0]       pass_nonce, tgt;
  logic [15:0]       msg_base, wr_ptr;
  // Word 19 (the header's own nonce field) is replaced by the lane nonce, so it is not kept.
  logic [18:0][31:0] hdr;
  logic [7:0][31:0]  midstate, p2_chain;
  logic [4:0]        hdr_idx;
  logic [5:0]        k_idx;
  logic              hash_phase, lane_load, lane_step, lane_fold;
  logic [LW-1:0]     lane_sel, win_idx;
  logic [NUM_LANES-1:0]            win;
  logic [NUM_LANES-1:0][31:0]      lane_h0;
  logic [NUM_LANES-1:0][7:0][31:0] lane_dig;

  assign mem_clk    = clk;
  assign done       = (state == IDLE);
  assign hdr_idx    = 5'(cnt - 7'd1);
  assign k_idx      = cnt[5:0] - 6'd1;   // cnt 64 wraps to 63
  assign lane_sel   = cnt[LW-1:0];
  assign hash_phase = (state == P1) || (state == P2) || (state == P3);
  assign lane_load  = hash_phase && (cnt == 7'd0);
  assign lane_step  = hash_phase && (cnt >= 7'd1) && (cnt <= 7'd64);
  assign lane_fold  = hash_phase && (cnt == 7'd65);

  // Lane 0's digest still holds the P1 result at the first P2 load. It is
  // used directly there and copied into midstate for the later passes.
  assign p2_chain = (pass == '0) ? lane_dig[0] : midstate;

  for (genvar m = 0; m < NUM_LANES; m++) begin : g_lane
    logic [15:0][31:0] blk_m;
    logic [7:0][31:0]  chn_m;
    logic [31:0]       nonce_m;

    assign nonce_m = pass_nonce + 32'(m);

    always_comb begin
      blk_m = hdr[15:0];
      chn_m = IV;
      if (state == P2) begin
        blk_m = {32'd640, {10{32'h0}}, 32'h80000000, nonce_m, hdr[18:16]};
        chn_m = p2_chain;
      end else if (state == P3) begin
        blk_m = {32'd256, {6{32'h0}}, 32'h80000000, lane_dig[m]};
      end
    end

    bitcoin_nonce_search_lane u_lane (
      .clk      (clk),
      .load     (lane_load),
      .step     (lane_step),
      .fold     (lane_fold),
      .k        (K[k_idx]),
      .blk      (blk_m),
      .chain_in (chn_m),
      .fold_h0  (lane_h0[m]),
      .digest   (lane_dig[m])
    );

    assign win[m] = lane_h0[m] < tgt;
  end

  // Lowest-index winning lane
  always_comb begin
    win_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) if (win[i]) win_idx = LW'(i);
  end

  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (state == READ && cnt < 7'd20) begin
      mem_addr = msg_base + 16'(cnt);
    end else if (state == WRITE) begin
      mem_we         = 1'b1;
      mem_addr       = wr_ptr;
      mem_write_data = lane_dig[lane_sel][0];
    end
  end

  always_ff @(posedge clk) begin
    if (state == READ && cnt >= 7'd1 && cnt <= 7'd19) hdr[hdr_idx] <= mem_read_data;
    if (state == P2 && cnt == 7'd0 && pass == '0) midstate <= lane_dig[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pass        <= '0;
      pass_nonce  <= '0;
      tgt         <= '0;
      msg_base    <= '0;
      wr_ptr      <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= READ;
          cnt         <= '0;
          pass        <= '0;
          pass_nonce  <= nonce_base;
          tgt         <= target;
          msg_base    <= message_addr;
          wr_ptr      <= output_addr;
          found       <= 1'b0;
          found_nonce <= '0;
        end
        READ: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd20) begin
            state <= P1;
            cnt   <= '0;
          end
        end
        P1, P2: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd65) begin
            state <= (state == P1) ? P2 : P3;
            cnt   <= '0;
          end
        end
        P3: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd65) begin
            state <= WRITE;
            cnt   <= '0;
            if (!found && (|win)) begin
              found       <= 1'b1;
              found_nonce <= pass_nonce + 32'(win_idx);
            end
          end
        end
        WRITE: begin
          wr_ptr <= wr_ptr + 16'd1;
          cnt    <= cnt + 7'd1;
          if (cnt == 7'(NUM_LANES - 1)) begin
            cnt <= '0;
            if (pass != PW'(NUM_PASSES - 1) && !((STOP_ON_FIND != 0) && found)) begin
              state      <= P2;
              pass       <= pass + 1'b1;
              pass_nonce <= pass_nonce + 32'(NUM_LANES);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bitcoin_nonce_search.md
Name: bitcoin_nonce_search

Overview:
- Parametrised successor to the fixed 8-lane, 16-nonce Bitcoin hasher.
- Reads a 20-word block header from memory and computes the shared first-block SHA-256 midstate once.
- Sweeps NUM_LANES*NUM_PASSES nonces starting at a programmable base, with NUM_LANES double-SHA-256 lanes running in parallel per pass.
- Writes each nonce's final h0 to memory and compares h0 against a difficulty target. It reports the lowest-index winning nonce and can optionally stop early.

Parameters:
- NUM_LANES, 8, parallel SHA-256 lanes per pass (1..16).
- NUM_PASSES, 2, nonce batches per run (1..256); total nonces = NUM_LANES*NUM_PASSES.
- STOP_ON_FIND, 0, 1 = skip remaining passes after the pass containing the first winner.

Ports:
- clk  in  1  system clock; also drives mem_clk.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- message_addr  in  16  base address of the 20 header words.
- output_addr  in  16  base address of the h0 output words.
- nonce_base  in  32  nonce of lane 0, pass 0.
- target  in  32  winner if final h0 < target (unsigned).
- done  out  1  high while in IDLE.
- found  out  1  a winner was seen in the last run.
- found_nonce  out  32  lowest-index winning nonce.
- mem_clk  out  1  equal to clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  read data, valid one cycle after the address is presented.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; done=1; found=0; found_nonce=0; mem_we=0; mem_addr=0; mem_write_data=0.
  - Reset asserted mid-run aborts immediately; no further writes are issued.
- IDLE:
  - start=1 latches nonce_base and target, clears found and found_nonce, and goes to READ.
  - start in any other state is ignored.
- READ (21 cycles):
  - Addresses message_addr+0..19 presented on consecutive cycles.
  - Word k is captured one cycle after its address.
- P1 (66 cycles), first block = header words 0..15:
  - 1 load cycle (a..h = IV), 64 round cycles, 1 fold cycle (midstate = IV + a..h).
  - Message schedule is a 16-entry shift window; one round per cycle.
- Per pass p, for lane m:
  - nonce = nonce_base + p*NUM_LANES + m, mod 2^32 (wraps 0xFFFFFFFF -> 0).
  - P2 (66 cycles): second block = {hdr16..18, nonce, 0x80000000, 0 x10, 640}; chaining value = midstate.
  - P3 (66 cycles): block = {P2 digest h0..h7, 0x80000000, 0 x6, 256}; chaining value = IV.
  - Result per lane = IV0 + a.
  - WRITE (NUM_LANES cycles): cycle m drives mem_we=1, mem_addr=output_addr+p*NUM_LANES+m, data=lane m h0.
  - mem_we=0 in every other state.
- Compare:
  - Done at P3 fold: lane m wins if h0 < target.
  - If found=0 and the pass has a winner: found=1 and found_nonce = nonce of the lowest winning lane.
  - Later winners never overwrite found_nonce.
- End of WRITE:
  - Next pass if passes remain and !(STOP_ON_FIND && found).
  - Otherwise IDLE.
  - Writes for skipped passes are not issued.
- Run length: cycles outside IDLE = 21 + 66 + P*(132+NUM_LANES), where P = passes executed.
- Arithmetic: all adds are mod 2^32. Rotates use constant amounts.
- Boundaries:
  - target=0: found never set.
  - target=0xFFFFFFFF: any h0 != 0xFFFFFFFF wins.
  - found and found_nonce hold their values in IDLE until the next accepted start.

Test Plan:
1. Defaults, nonce_base=0, target=0, known header:
   - Exactly 16 writes to output_addr..+15 matching the software model h0 for nonces 0..15.
   - found=0; done low for 21+66+2*140=367 cycles.
2. target=0xFFFFFFFF, nonce_base=0x100:
   - found=1, found_nonce=0x100 (given model h0 != 0xFFFFFFFF).
3. STOP_ON_FIND=1, target = model h0 of nonce 3, plus 1, chosen so nonces 0..2 lose:
   - found_nonce=3; only 8 writes; run is 87+140 cycles.
   - Repeat with STOP_ON_FIND=0: 16 writes, found_nonce unchanged.
4. nonce_base=0xFFFFFFFC, NUM_LANES=8, NUM_PASSES=1:
   - Lanes hash nonces FFFFFFFC..FFFFFFFF, 0..3; written h0 values match the model.
5. Reset pulsed on the 50th P2 round cycle:
   - Next cycle done=1, mem_we=0; no writes afterwards.
   - A new start completes a normal run with correct outputs.
6. start pulsed repeatedly during the run:
   - Ignored; output identical to scenario 1.
   - NUM_LANES=1, NUM_PASSES=4 variant also matches the model.
